// File: rtl/acknowledge_sequencer_if.sv
// Handshake bundle between the interrupt controller core and the INTA/poll acknowledge sequencer.
// The slave modport is the sequencer's view; the master modport is the controller side.
interface acknowledge_sequencer_if;
  logic       interrupt_acknowledge_n;
  logic       read;
  logic       u8086_or_mcs80_config;
  logic       write_initial_command_word_1;
  logic       poll_command;
  logic       cascade_slave;
  logic       cascade_slave_enable;
  logic [7:0] interrupt;

  logic [2:0] control_state;
  logic [7:0] interrupt_when_ack1;
  logic [7:0] acknowledge_interrupt;
  logic       cascade_output_ack_2_3;
  logic [7:0] in_service_set;
  logic       end_of_acknowledge_sequence;

  modport slave (
    input  interrupt_acknowledge_n, read, u8086_or_mcs80_config,
           write_initial_command_word_1, poll_command,
           cascade_slave, cascade_slave_enable, interrupt,
    output control_state, interrupt_when_ack1, acknowledge_interrupt,
           cascade_output_ack_2_3, in_service_set, end_of_acknowledge_sequence
  );

  modport master (
    output interrupt_acknowledge_n, read, u8086_or_mcs80_config,
           write_initial_command_word_1, poll_command,
           cascade_slave, cascade_slave_enable, interrupt,
    input  control_state, interrupt_when_ack1, acknowledge_interrupt,
           cascade_output_ack_2_3, in_service_set, end_of_acknowledge_sequence
  );
endinterface

// File: rtl/acknowledge_sequencer.sv
// INTA / poll acknowledge sequencer: tracks 8086 (2-pulse) and MCS-80/85 (3-pulse)
// acknowledge cycles plus poll reads, and produces ISR set and end-of-sequence pulses.
//
// state   | meaning
// READY   | idle, waiting for first INTA falling edge or a poll command
// ACK1    | first INTA pulse seen, IR latched and ISR bit set
// ACK2    | second INTA pulse; 8086 ends on its rising edge
// ACK3    | third INTA pulse (MCS-80/85 only)
// POLL    | poll armed, waiting for the end of the CPU read
module acknowledge_sequencer (
  input  logic                          clock,
  input  logic                          reset_n,
  acknowledge_sequencer_if.slave        bus
);

  typedef enum logic [2:0] {
    S_READY = 3'b000,
    S_ACK1  = 3'b001,
    S_ACK2  = 3'b010,
    S_ACK3  = 3'b011,
    S_POLL  = 3'b100
  } state_t;

  state_t     r_state;
  logic       r_prev_inta_n;
  logic       r_prev_read;
  logic [7:0] r_iwa1;
  logic [7:0] r_ack_irq;
  logic       r_cas_out;
  logic [7:0] r_isr_set;
  logic       r_eoi;

  state_t     w_state_nxt;
  logic [7:0] w_iwa1_nxt;
  logic [7:0] w_ack_irq_nxt;
  logic       w_cas_out_nxt;
  logic [7:0] w_isr_set_nxt;
  logic       w_eoi_nxt;
  logic       w_nedge;
  logic       w_pedge;
  logic       w_read_end;
  logic       w_finish;

  assign w_nedge    = r_prev_inta_n & ~bus.interrupt_acknowledge_n;
  assign w_pedge    = ~r_prev_inta_n & bus.interrupt_acknowledge_n;
  assign w_read_end = r_prev_read & ~bus.read;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_READY;
      r_prev_inta_n <= 1'b1;
      r_prev_read   <= 1'b0;
      r_iwa1        <= 8'h00;
      r_ack_irq     <= 8'h00;
      r_cas_out     <= 1'b0;
      r_isr_set     <= 8'h00;
      r_eoi         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_prev_inta_n <= bus.interrupt_acknowledge_n;
      r_prev_read   <= bus.read;
      r_iwa1        <= w_iwa1_nxt;
      r_ack_irq     <= w_ack_irq_nxt;
      r_cas_out     <= w_cas_out_nxt;
      r_isr_set     <= w_isr_set_nxt;
      r_eoi         <= w_eoi_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_iwa1_nxt    = r_iwa1;
    w_ack_irq_nxt = r_ack_irq;
    w_cas_out_nxt = r_cas_out;
    w_isr_set_nxt = 8'h00;
    w_eoi_nxt     = 1'b0;
    w_finish      = 1'b0;

    // ICW1 reinitialises the controller, so it beats any INTA edge or poll in the same cycle
    if (bus.write_initial_command_word_1) begin
      w_state_nxt   = S_READY;
      w_iwa1_nxt    = 8'h00;
      w_ack_irq_nxt = 8'h00;
      w_cas_out_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_READY: begin
          if (w_nedge) begin
            w_state_nxt   = S_ACK1;
            w_iwa1_nxt    = bus.interrupt;
            w_ack_irq_nxt = bus.interrupt;
            w_isr_set_nxt = bus.interrupt;
            w_cas_out_nxt = ~bus.cascade_slave | bus.cascade_slave_enable;
          end else if (bus.poll_command) begin
            w_state_nxt = S_POLL;
          end
        end
        S_ACK1: begin
          if (w_nedge) w_state_nxt = S_ACK2;
        end
        S_ACK2: begin
          // mode is sampled here so a mid-sequence config change lands at this decision
          if (bus.u8086_or_mcs80_config) begin
            if (w_nedge) w_state_nxt = S_ACK3;
          end else if (w_pedge) begin
            w_finish = 1'b1;
          end
        end
        S_ACK3: begin
          if (w_pedge) w_finish = 1'b1;
        end
        S_POLL: begin
          if (w_read_end) begin
            w_state_nxt   = S_READY;
            w_isr_set_nxt = bus.interrupt;
            w_eoi_nxt     = 1'b1;
          end
        end
        default: w_state_nxt = S_READY;
      endcase

      if (w_finish) begin
        w_state_nxt   = S_READY;
        w_ack_irq_nxt = 8'h00;
        w_cas_out_nxt = 1'b0;
        w_eoi_nxt     = 1'b1;
      end
    end
  end

  assign bus.control_state               = r_state;
  assign bus.interrupt_when_ack1         = r_iwa1;
  assign bus.acknowledge_interrupt       = r_ack_irq;
  assign bus.cascade_output_ack_2_3      = r_cas_out;
  assign bus.in_service_set              = r_isr_set;
  assign bus.end_of_acknowledge_sequence = r_eoi;

endmodule

// File: tb/tb_acknowledge_sequencer.sv
// Directed bench for acknowledge_sequencer: a per-cycle vector table plus hand-written
// sequences for asynchronous reset mid-ACK3 and the spurious (no IR) acknowledge.
module tb_acknowledge_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  acknowledge_sequencer_if bus ();

  acknowledge_sequencer dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       inta_n;
    logic       rd;
    logic       mode;
    logic       icw1;
    logic       poll;
    logic       cs;
    logic       cse;
    logic [7:0] irq;
    logic [2:0] e_state;
    logic [7:0] e_iwa1;
    logic [7:0] e_ack;
    logic       e_cas;
    logic [7:0] e_isr;
    logic       e_eoi;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic inta_n, input logic rd, input logic mode, input logic icw1,
                   input logic poll, input logic cs, input logic cse, input logic [7:0] irq,
                   input logic [2:0] st, input logic [7:0] iwa1, input logic [7:0] ack,
                   input logic cas, input logic [7:0] isr, input logic eoi);
    vec_t x;
    x.inta_n = inta_n; x.rd = rd; x.mode = mode; x.icw1 = icw1; x.poll = poll;
    x.cs = cs; x.cse = cse; x.irq = irq;
    x.e_state = st; x.e_iwa1 = iwa1; x.e_ack = ack; x.e_cas = cas; x.e_isr = isr; x.e_eoi = eoi;
    vecs.push_back(x);
  endtask

  task automatic drive(input vec_t x);
    bus.interrupt_acknowledge_n      = x.inta_n;
    bus.read                         = x.rd;
    bus.u8086_or_mcs80_config        = x.mode;
    bus.write_initial_command_word_1 = x.icw1;
    bus.poll_command                 = x.poll;
    bus.cascade_slave                = x.cs;
    bus.cascade_slave_enable         = x.cse;
    bus.interrupt                    = x.irq;
  endtask

  task automatic check_outputs(input string name, input logic [2:0] st, input logic [7:0] iwa1,
                               input logic [7:0] ack, input logic cas, input logic [7:0] isr,
                               input logic eoi);
    n_checks++;
    if (bus.control_state !== st || bus.interrupt_when_ack1 !== iwa1 ||
        bus.acknowledge_interrupt !== ack || bus.cascade_output_ack_2_3 !== cas ||
        bus.in_service_set !== isr || bus.end_of_acknowledge_sequence !== eoi) begin
      n_fail++;
      $display("FAIL %s: got st=%b iwa1=%h ack=%h cas=%b isr=%h eoi=%b, want st=%b iwa1=%h ack=%h cas=%b isr=%h eoi=%b",
               name, bus.control_state, bus.interrupt_when_ack1, bus.acknowledge_interrupt,
               bus.cascade_output_ack_2_3, bus.in_service_set, bus.end_of_acknowledge_sequence,
               st, iwa1, ack, cas, isr, eoi);
    end
  endtask

  task automatic step(input logic inta_n, input logic mode, input logic [7:0] irq);
    vec_t x;
    x = '{inta_n: inta_n, rd: 1'b0, mode: mode, icw1: 1'b0, poll: 1'b0, cs: 1'b0, cse: 1'b0,
          irq: irq, e_state: 3'd0, e_iwa1: 8'h00, e_ack: 8'h00, e_cas: 1'b0, e_isr: 8'h00,
          e_eoi: 1'b0};
    @(negedge clk);
    drive(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.interrupt_acknowledge_n      = 1'b1;
    bus.read                         = 1'b0;
    bus.u8086_or_mcs80_config        = 1'b1;
    bus.write_initial_command_word_1 = 1'b0;
    bus.poll_command                 = 1'b0;
    bus.cascade_slave                = 1'b0;
    bus.cascade_slave_enable         = 1'b0;
    bus.interrupt                    = 8'h00;

    // MCS-80, IR2, three pulses
    v(1,0,1,0,0,0,0,8'h04, 3'd0,8'h00,8'h00,0,8'h00,0);
    v(0,0,1,0,0,0,0,8'h04, 3'd1,8'h04,8'h04,1,8'h04,0);
    v(0,0,1,0,0,0,0,8'h04, 3'd1,8'h04,8'h04,1,8'h00,0);
    v(1,0,1,0,0,0,0,8'h04, 3'd1,8'h04,8'h04,1,8'h00,0);
    v(0,0,1,0,0,0,0,8'h04, 3'd2,8'h04,8'h04,1,8'h00,0);
    v(1,0,1,0,0,0,0,8'h04, 3'd2,8'h04,8'h04,1,8'h00,0);
    v(0,0,1,0,0,0,0,8'h04, 3'd3,8'h04,8'h04,1,8'h00,0);
    v(1,0,1,0,0,0,0,8'h04, 3'd0,8'h04,8'h00,0,8'h00,1);
    v(1,0,1,0,0,0,0,8'h04, 3'd0,8'h04,8'h00,0,8'h00,0);
    // 8086, IR1, slave not addressed
    v(0,0,0,0,0,1,0,8'h02, 3'd1,8'h02,8'h02,0,8'h02,0);
    v(1,0,0,0,0,1,0,8'h02, 3'd1,8'h02,8'h02,0,8'h00,0);
    v(0,0,0,0,0,1,0,8'h02, 3'd2,8'h02,8'h02,0,8'h00,0);
    v(1,0,0,0,0,1,0,8'h02, 3'd0,8'h02,8'h00,0,8'h00,1);
    v(1,0,0,0,0,1,0,8'h02, 3'd0,8'h02,8'h00,0,8'h00,0);
    // addressed slave; IR changes after latch; mode flips to MCS-80 before the ACK2 decision
    v(0,0,0,0,0,1,1,8'h01, 3'd1,8'h01,8'h01,1,8'h01,0);
    v(1,0,0,0,0,1,1,8'h20, 3'd1,8'h01,8'h01,1,8'h00,0);
    v(0,0,0,0,0,1,1,8'h20, 3'd2,8'h01,8'h01,1,8'h00,0);
    v(1,0,1,0,0,1,1,8'h20, 3'd2,8'h01,8'h01,1,8'h00,0);
    v(0,0,1,0,0,1,1,8'h20, 3'd3,8'h01,8'h01,1,8'h00,0);
    v(1,0,1,0,0,1,1,8'h20, 3'd0,8'h01,8'h00,0,8'h00,1);
    // poll, read high then low
    v(1,0,0,0,1,0,0,8'h80, 3'd4,8'h01,8'h00,0,8'h00,0);
    v(1,1,0,0,0,0,0,8'h80, 3'd4,8'h01,8'h00,0,8'h00,0);
    v(1,0,0,0,0,0,0,8'h80, 3'd0,8'h01,8'h00,0,8'h80,1);
    v(1,0,0,0,0,0,0,8'h80, 3'd0,8'h01,8'h00,0,8'h00,0);
    // INTA edges ignored while polling
    v(1,0,0,0,1,0,0,8'h80, 3'd4,8'h01,8'h00,0,8'h00,0);
    v(0,0,0,0,0,0,0,8'h80, 3'd4,8'h01,8'h00,0,8'h00,0);
    v(1,0,0,0,0,0,0,8'h80, 3'd4,8'h01,8'h00,0,8'h00,0);
    v(1,1,0,0,0,0,0,8'h80, 3'd4,8'h01,8'h00,0,8'h00,0);
    v(1,0,0,0,0,0,0,8'h80, 3'd0,8'h01,8'h00,0,8'h80,1);
    // poll ignored in ACK1, then ICW1 coincident with ACK2 nedge
    v(0,0,1,0,0,0,0,8'h08, 3'd1,8'h08,8'h08,1,8'h08,0);
    v(1,0,1,0,1,0,0,8'h08, 3'd1,8'h08,8'h08,1,8'h00,0);
    v(0,0,1,0,0,0,0,8'h08, 3'd2,8'h08,8'h08,1,8'h00,0);
    v(1,0,1,0,0,0,0,8'h08, 3'd2,8'h08,8'h08,1,8'h00,0);
    v(0,0,1,1,0,0,0,8'h08, 3'd0,8'h00,8'h00,0,8'h00,0);
    v(1,0,1,0,0,0,0,8'h08, 3'd0,8'h00,8'h00,0,8'h00,0);

    #2;
    check_outputs("reset_state", 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_iwa1, vecs[i].e_ack,
                    vecs[i].e_cas, vecs[i].e_isr, vecs[i].e_eoi);
    end

    // asynchronous reset during ACK3
    step(0, 1'b1, 8'h10);
    check_outputs("rst_ack1", 3'd1, 8'h10, 8'h10, 1'b1, 8'h10, 1'b0);
    step(1, 1'b1, 8'h10);
    step(0, 1'b1, 8'h10);
    step(1, 1'b1, 8'h10);
    step(0, 1'b1, 8'h10);
    check_outputs("rst_ack3", 3'd3, 8'h10, 8'h10, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs("rst_async", 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    bus.interrupt_acknowledge_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("rst_held_no_eoi", 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // spurious acknowledge, 8086
    step(1, 1'b0, 8'h00);
    step(0, 1'b0, 8'h00);
    check_outputs("spur_ack1", 3'd1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    step(1, 1'b0, 8'h00);
    step(0, 1'b0, 8'h00);
    check_outputs("spur_ack2", 3'd2, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    step(1, 1'b0, 8'h00);
    check_outputs("spur_end", 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1, 1'b0, 8'h00);
    check_outputs("spur_idle", 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acknowledge_sequencer.md
ACKNOWLEDGE_SEQUENCER -- requirements
Module: acknowledge_sequencer

Interface
REQ-001 clock  in  1  single system clock; all state updates on its rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 interrupt_acknowledge_n  in  1  INTA# pin, already synchronous to clock.
REQ-004 read  in  1  CPU read strobe; high = read cycle active.
REQ-005 u8086_or_mcs80_config  in  1  1 = MCS-80/85 (3 INTA pulses), 0 = 8086 (2 pulses).
REQ-006 write_initial_command_word_1  in  1  one-cycle ICW1 write pulse.
REQ-007 poll_command  in  1  one-cycle OCW3 poll-command pulse.
REQ-008 cascade_slave  in  1  1 = this device is a slave.
REQ-009 cascade_slave_enable  in  1  1 = slave ID on CAS lines matches this device.
REQ-010 interrupt  in  8  one-hot highest-priority pending IR from the priority resolver; 0 = none.
REQ-011 control_state  out  3  000 READY, 001 ACK1, 010 ACK2, 011 ACK3, 100 POLL.
REQ-012 interrupt_when_ack1  out  8  IR latched at the ACK1 falling edge.
REQ-013 acknowledge_interrupt  out  8  IR being acknowledged; equals interrupt_when_ack1 from ACK1 until sequence end.
REQ-014 cascade_output_ack_2_3  out  1  1 = this device drives the data bus in ACK2/ACK3.
REQ-015 in_service_set  out  8  one-cycle pulse selecting the ISR bit to set.
REQ-016 end_of_acknowledge_sequence  out  1  one-cycle pulse at sequence completion (auto-EOI hook).

Function
REQ-017 The block SHALL register interrupt_acknowledge_n and read each cycle (prev_inta_n, prev_read); nedge = prev_inta_n & ~interrupt_acknowledge_n; pedge = ~prev_inta_n & interrupt_acknowledge_n; read_end = prev_read & ~read.
REQ-018 READY -> ACK1 on nedge; latch interrupt_when_ack1 <= interrupt; pulse in_service_set <= interrupt the same cycle.
REQ-019 At that transition cascade_output_ack_2_3 SHALL register ~cascade_slave | cascade_slave_enable and hold until return to READY.
REQ-020 ACK1 -> ACK2 on nedge.
REQ-021 ACK2 on pedge: 8086 mode -> READY with end_of_acknowledge_sequence pulse; MCS-80 mode -> stay ACK2.
REQ-022 ACK2 -> ACK3 on nedge (MCS-80 only); ACK3 on pedge -> READY with end_of_acknowledge_sequence pulse.
REQ-023 READY or POLL -> POLL on poll_command; POLL on read_end -> READY, pulsing in_service_set <= interrupt and end_of_acknowledge_sequence.
REQ-024 INTA edges SHALL be ignored in POLL; poll_command SHALL be ignored in ACK1/ACK2/ACK3.
REQ-025 Spurious case: interrupt = 0 at ACK1 nedge latches 0, in_service_set stays 0, sequence proceeds normally.
REQ-026 write_initial_command_word_1 SHALL force READY and clear interrupt_when_ack1, acknowledge_interrupt and cascade_output_ack_2_3 next cycle, overriding any simultaneous edge or poll_command.
REQ-027 acknowledge_interrupt SHALL clear to 0 in the same cycle the state returns to READY.
REQ-028 Mode change mid-sequence SHALL take effect at the next ACK2 decision; no other side effect.

Reset
REQ-029 reset_n low SHALL asynchronously set control_state=000, all 8-bit outputs=0, cascade_output_ack_2_3=0, end_of_acknowledge_sequence=0, prev_inta_n=1, prev_read=0.
REQ-030 Reset asserted mid-sequence SHALL abort to READY without an end_of_acknowledge_sequence pulse.

Verification
REQ-031 MCS-80, interrupt=00000100, three INTA pulses -> states 001,010,011,000; in_service_set=00000100 one cycle at first nedge; one end pulse at third pedge.
REQ-032 8086, interrupt=00000010, two pulses -> 001,010,000; end pulse at second pedge; acknowledge_interrupt=00000010 throughout, 0 after.
REQ-033 cascade_slave=1, cascade_slave_enable=0 at ACK1 -> cascade_output_ack_2_3=0; with enable=1 -> 1.
REQ-034 poll_command then read high/low with interrupt=10000000 -> state 100, then 000 with in_service_set=10000000 and end pulse.
REQ-035 ICW1 pulse in ACK2 coincident with nedge -> state 000, latches cleared, no end pulse.
REQ-036 reset_n low during ACK3 -> immediate 000, all outputs 0; interrupt=0 at ACK1 -> in_service_set stays 0.
